// File: rtl/weight_load_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Interface : weight_load_ctrl_if                                         |
// | Purpose   : Weight-word stream between the AXI-side source and the      |
// |             weight_load_ctrl sequencer (valid/ready handshake).         |
// | Signals   : s_valid  source -> sequencer, word valid                    |
// |             s_data   source -> sequencer, 32-bit weight word            |
// |             s_ready  sequencer -> source, word accepted when both high  |
// | Modports  : master = stream source, slave = weight_load_ctrl            |
// | Revision  : 1.0  initial release                                        |
// ---------------------------------------------------------------------------
interface weight_load_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module    : weight_load_ctrl                                            |
// | Purpose   : Fills the weight_array column buffers column-major from a   |
// |             32-bit word stream (one-hot fifo_en), then drains them with |
// |             a diagonally skewed out_en pattern for systolic feed.       |
// | Ports     : clk, nrst (synchronous, active-high)                        |
// |             start / words_per_col : begin a load job                    |
// |             s (slave modport)     : weight-word stream                  |
// |             weight_in / fifo_en   : registered word + buffer write en   |
// |             rd_start / out_en     : begin drain + skewed read enables   |
// |             busy, load_done, done, cfg_err : status                     |
// |             stall_cnt (only with WLC_STALL_CNT_EN defined) : count of   |
// |             LOAD cycles with s_valid low, saturating                    |
// | Option    : `define WLC_STALL_CNT_EN to add the stall_cnt output        |
// | Revision  : 1.0  initial release                                        |
// ---------------------------------------------------------------------------
module weight_load_ctrl #(
  parameter int COL   = 32,
  parameter int DEPTH = 16,
  // Derived from DEPTH; leave at its default.
  parameter int WPC_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [WPC_W-1:0]     words_per_col,
  weight_load_ctrl_if.slave    s,
  output logic [31:0]          weight_in,
  output logic [COL-1:0]       fifo_en,
  input  logic                 rd_start,
  output logic [COL-1:0]       out_en,
  output logic                 busy,
  output logic                 load_done,
  output logic                 done,
`ifdef WLC_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic                 cfg_err
);

  localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;
  // Drain counter must reach COL+DEPTH-2.
  localparam int T_W   = $clog2(COL + DEPTH);

  localparam logic [WPC_W-1:0] C_DEPTH    = WPC_W'(DEPTH);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(COL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WPC_W-1:0] wpc_q;
  logic [WPC_W-1:0] word_q;
  logic [COL_W-1:0] col_q;
  logic [T_W-1:0]   t_q;
  logic [31:0]      weight_in_q;
  logic [COL-1:0]   fifo_en_q;
  logic [COL-1:0]   out_en_q;
  logic             s_ready_q;
  logic             busy_q;
  logic             load_done_q;
  logic             done_q;
  logic             cfg_err_q;
`ifdef WLC_STALL_CNT_EN
  logic [15:0]      stall_q;
`endif

  logic [T_W-1:0]   t_d;
  logic [T_W-1:0]   t_last;
  logic [COL-1:0]   out_en_d;
  logic             wpc_bad;
  logic             hs;

  assign wpc_bad = (words_per_col == '0) || (words_per_col > C_DEPTH);
  assign hs      = s.s_valid && s_ready_q;
  assign t_last  = T_W'(COL - 2) + T_W'(wpc_q);

  // out_en is registered, so it is computed for the drain step about to
  // start: step 0 when leaving LOADED, otherwise the step after t_q.
  always_comb begin
    t_d      = (state_q == ST_LOADED) ? '0 : t_q + 1'b1;
    out_en_d = '0;
    for (int i = 0; i < COL; i++) begin
      out_en_d[i] = (int'(t_d) >= i) && (int'(t_d) < i + int'(wpc_q));
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= ST_IDLE;
      wpc_q       <= '0;
      word_q      <= '0;
      col_q       <= '0;
      t_q         <= '0;
      weight_in_q <= '0;
      fifo_en_q   <= '0;
      out_en_q    <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef WLC_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      fifo_en_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (wpc_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              wpc_q     <= words_per_col;
              word_q    <= '0;
              col_q     <= '0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= ST_LOAD;
`ifdef WLC_STALL_CNT_EN
              stall_q   <= '0;
`endif
            end
          end
        end
        ST_LOAD: begin
`ifdef WLC_STALL_CNT_EN
          if (!s.s_valid && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
`endif
          if (hs) begin
            weight_in_q        <= s.s_data;
            fifo_en_q[col_q]   <= 1'b1;
            if (word_q == wpc_q - 1'b1) begin
              word_q <= '0;
              if (col_q == C_COL_LAST) begin
                // Final word: ready drops next cycle so nothing more is taken.
                s_ready_q   <= 1'b0;
                load_done_q <= 1'b1;
                state_q     <= ST_LOADED;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        ST_LOADED: begin
          if (rd_start) begin
            load_done_q <= 1'b0;
            t_q         <= '0;
            out_en_q    <= out_en_d;
            state_q     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (t_q == t_last) begin
            out_en_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            t_q      <= t_d;
            out_en_q <= out_en_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s.s_ready = s_ready_q;
  assign weight_in = weight_in_q;
  assign fifo_en   = fifo_en_q;
  assign out_en    = out_en_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
`ifdef WLC_STALL_CNT_EN
  assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module    : tb_weight_load_ctrl                                         |
// | Purpose   : Self-checking bench for weight_load_ctrl (COL=4, DEPTH=8).  |
// |             Reference: expected column per word is word_index/wpc, and  |
// |             the drain pattern is built by marking wpc consecutive steps |
// |             starting at step i for every column i.                      |
// | Option    : stall_cnt is checked when WLC_STALL_CNT_EN is defined       |
// | Revision  : 1.0  initial release                                        |
// ---------------------------------------------------------------------------
module tb_weight_load_ctrl;
  localparam int COL   = 4;
  localparam int DEPTH = 8;
  localparam int WPC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             nrst;
  logic             start;
  logic             rd_start;
  logic [WPC_W-1:0] words_per_col;
  logic [31:0]      weight_in;
  logic [COL-1:0]   fifo_en;
  logic [COL-1:0]   out_en;
  logic             busy;
  logic             load_done;
  logic             done;
  logic             cfg_err;
`ifdef WLC_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  weight_load_ctrl_if sif ();

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_w = '0;

  weight_load_ctrl #(.COL(COL), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .words_per_col (words_per_col),
    .s             (sif),
    .weight_in     (weight_in),
    .fifo_en       (fifo_en),
    .rd_start      (rd_start),
    .out_en        (out_en),
    .busy          (busy),
    .load_done     (load_done),
    .done          (done),
`ifdef WLC_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    repeat (3) tick();
    last_w = '0;
    checks++;
    if ({sif.s_ready, busy, load_done, done, cfg_err, fifo_en, out_en, weight_in} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b ld=%b done=%b err=%b fen=%b oen=%b w=%h, expected all 0",
               sif.s_ready, busy, load_done, done, cfg_err, fifo_en, out_en, weight_in);
    end
`ifdef WLC_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt);
    end
`endif
    nrst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b ready=%b, expected 0 0", busy, sif.s_ready);
    end
  endtask

  // mode 0: back-to-back words 0x10+k; mode 1: valid every 2nd cycle;
  // mode 2: random gaps. noise: random start/rd_start/words_per_col while loading.
  task automatic test_load(input int wpc, input int mode, input bit noise);
    int             nwords;
    int             sent;
    int             cyc;
    int             stalls;
    bit             v;
    logic [31:0]    d;
    logic [COL-1:0] exp_en;
    nwords = COL * wpc;
    sent   = 0;
    cyc    = 0;
    stalls = 0;
    start = 1'b1;
    words_per_col = WPC_W'(wpc);
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sif.s_ready !== 1'b1 || load_done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL load_entry: got busy=%b ready=%b ld=%b err=%b, expected 1 1 0 0",
               busy, sif.s_ready, load_done, cfg_err);
    end
    while (sent < nwords && cyc < 40 * nwords) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = (mode == 0) ? 32'h10 + 32'(sent) : $urandom;
      sif.s_valid = v;
      sif.s_data  = d;
      if (noise) begin
        start         = 1'($urandom_range(0, 1));
        rd_start      = 1'($urandom_range(0, 1));
        words_per_col = WPC_W'($urandom);
      end
      tick();
      cyc++;
      start    = 1'b0;
      rd_start = 1'b0;
      exp_en   = '0;
      if (v) begin
        exp_en[sent / wpc] = 1'b1;
        last_w = d;
        sent++;
      end else begin
        stalls++;
      end
      checks++;
      if (fifo_en !== exp_en || weight_in !== last_w || cfg_err !== 1'b0 ||
          sif.s_ready !== (sent < nwords) || load_done !== (sent == nwords)) begin
        errors++;
        $display("FAIL load_word%0d: got fen=%b w=%h err=%b ready=%b ld=%b, expected fen=%b w=%h err=0 ready=%b ld=%b",
                 sent, fifo_en, weight_in, cfg_err, sif.s_ready, load_done,
                 exp_en, last_w, (sent < nwords), (sent == nwords));
      end
    end
    if (sent < nwords) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d words, expected %0d", sent, nwords);
    end
    // An offered word after the final one must not be taken.
    sif.s_valid = 1'b1;
    sif.s_data  = $urandom;
    tick();
    sif.s_valid = 1'b0;
    checks++;
    if (fifo_en !== '0 || weight_in !== last_w || load_done !== 1'b1 || busy !== 1'b1 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL loaded_hold: got fen=%b w=%h ld=%b busy=%b ready=%b, expected 0 %h 1 1 0",
               fifo_en, weight_in, load_done, busy, sif.s_ready, last_w);
    end
`ifdef WLC_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(stalls)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, stalls);
    end
`endif
  endtask

  task automatic test_drain(input int wpc, input bit noise);
    logic [COL-1:0] exp [COL+DEPTH];
    int             steps;
    steps = COL + wpc - 1;
    foreach (exp[t]) exp[t] = '0;
    for (int i = 0; i < COL; i++)
      for (int k = 0; k < wpc; k++)
        exp[i + k][i] = 1'b1;
    if (noise) begin
      start = 1'b1;
      words_per_col = WPC_W'(2);
      tick();
      start = 1'b0;
      checks++;
      if (load_done !== 1'b1 || busy !== 1'b1 || out_en !== '0 || cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL start_in_loaded: got ld=%b busy=%b oen=%b err=%b, expected 1 1 0 0",
                 load_done, busy, out_en, cfg_err);
      end
    end
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int t = 0; t < steps; t++) begin
      checks++;
      if (out_en !== exp[t] || done !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_t%0d: got oen=%b done=%b busy=%b ld=%b, expected oen=%b done=0 busy=1 ld=0",
                 t, out_en, done, busy, load_done, exp[t]);
      end
      if (noise) begin
        start         = 1'($urandom_range(0, 1));
        rd_start      = 1'($urandom_range(0, 1));
        words_per_col = WPC_W'($urandom);
      end
      tick();
      start    = 1'b0;
      rd_start = 1'b0;
    end
    checks++;
    if (out_en !== '0 || done !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: got oen=%b done=%b busy=%b err=%b, expected 0 1 0 0",
               out_en, done, busy, cfg_err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_en !== '0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b oen=%b, expected 0 0 0", done, busy, out_en);
    end
  endtask

  task automatic test_cfg_err();
    int bad [3] = '{0, 9, 15};
    for (int j = 0; j < 3; j++) begin
      start = 1'b1;
      words_per_col = WPC_W'(bad[j]);
      tick();
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || fifo_en !== '0 || sif.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_wpc%0d: got err=%b busy=%b fen=%b ready=%b, expected 1 0 0 0",
                 bad[j], cfg_err, busy, fifo_en, sif.s_ready);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || fifo_en !== '0) begin
        errors++;
        $display("FAIL cfg_err_pulse_wpc%0d: got err=%b busy=%b fen=%b, expected 0 0 0",
                 bad[j], cfg_err, busy, fifo_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    words_per_col = WPC_W'(2);
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = 32'h20 + 32'(k);
      tick();
    end
    sif.s_valid = 1'b0;
    nrst = 1'b1;
    tick();
    last_w = '0;
    checks++;
    if ({sif.s_ready, busy, load_done, done, cfg_err, fifo_en, out_en, weight_in} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: got ready=%b busy=%b ld=%b fen=%b w=%h, expected all 0",
               sif.s_ready, busy, load_done, fifo_en, weight_in);
    end
    nrst = 1'b0;
    tick();
  endtask

  initial begin
    int w;
    nrst          = 1'b1;
    start         = 1'b0;
    rd_start      = 1'b0;
    words_per_col = '0;
    sif.s_valid   = 1'b0;
    sif.s_data    = '0;

    test_reset();
    test_load(2, 0, 1'b0);
    test_drain(2, 1'b0);
    test_cfg_err();
    test_load(2, 1, 1'b0);
    test_drain(2, 1'b0);
    test_reset_mid();
    test_load(1, 0, 1'b0);
    test_drain(1, 1'b0);
    test_load(3, 2, 1'b1);
    test_drain(3, 1'b1);
    test_load(DEPTH, 0, 1'b0);
    test_drain(DEPTH, 1'b0);
    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(1, DEPTH);
      test_load(w, 2, 1'b0);
      test_drain(w, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
